// File: rtl/mmcm_drp_sequencer_if.sv
// DRP bus between the reconfiguration sequencer (master) and an MMCME2/PLLE2 DRP port (slave).
interface mmcm_drp_sequencer_if;
    logic [6:0]  daddr;
    logic [15:0] din;
    logic        den;
    logic        dwe;
    logic [15:0] dout;
    logic        drdy;

    modport master (output daddr, din, den, dwe, input dout, drdy);
    modport slave  (input daddr, din, den, dwe, output dout, drdy);
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// Table-driven MMCM/PLL DRP reconfiguration: holds the MMCM in reset, read-modify-writes each
// active table entry, releases reset and waits for lock, with drdy/lock timeouts.
module mmcm_drp_sequencer #(
    parameter int NUM_ENTRIES  = 23,
    parameter int IDX_W        = 5,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                 i_dclk,
    input  logic                 i_rst,
    input  logic                 i_tbl_we,
    input  logic [IDX_W-1:0]     i_tbl_idx,
    input  logic [6:0]           i_tbl_addr,
    input  logic [15:0]          i_tbl_mask,
    input  logic [15:0]          i_tbl_data,
    input  logic [IDX_W:0]       i_num_active,
    input  logic                 i_start,
    mmcm_drp_sequencer_if.master drp,
    output logic                 o_rst_mmcm,
    input  logic                 i_locked,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_error,
    output logic [1:0]           o_err_code
);
    typedef enum logic [3:0] {
        S_IDLE, S_ASSERT_RST, S_READ, S_READ_WAIT, S_WRITE, S_WRITE_WAIT,
        S_RELEASE, S_WAIT_LOCK, S_DONE
    } state_t;

    localparam int             TMAX         = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int             CNT_W        = $clog2(TMAX + 1);
    localparam int             LOCK_HOLDOFF = 4;
    localparam logic [IDX_W:0] W_NE         = (IDX_W+1)'(NUM_ENTRIES);

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_tbl_addr [NUM_ENTRIES];
    logic [15:0]      r_tbl_mask [NUM_ENTRIES];
    logic [15:0]      r_tbl_data [NUM_ENTRIES];
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W:0]   r_num;
    logic [15:0]      r_new;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lock_sync;
    logic             r_error;
    logic [1:0]       r_err_code;

    logic w_idx_ok, w_range_err, w_drdy_to, w_lock_to, w_lock_ok, w_last;

    assign w_idx_ok    = {1'b0, i_tbl_idx} < W_NE;
    assign w_range_err = i_num_active > W_NE;
    assign w_drdy_to   = r_cnt == CNT_W'(DRDY_TIMEOUT - 1);
    assign w_lock_to   = r_cnt == CNT_W'(LOCK_TIMEOUT - 1);
    // A locked left over from before the reset pulse must not end the wait early.
    assign w_lock_ok   = (r_cnt >= CNT_W'(LOCK_HOLDOFF)) && r_lock_sync[1];
    assign w_last      = ({1'b0, r_idx} + (IDX_W+1)'(1)) == r_num;

    always_ff @(posedge i_dclk) begin
        if (i_tbl_we && r_state == S_IDLE && w_idx_ok) begin
            r_tbl_addr[i_tbl_idx] <= i_tbl_addr;
            r_tbl_mask[i_tbl_idx] <= i_tbl_mask;
            r_tbl_data[i_tbl_idx] <= i_tbl_data;
        end
    end

    always_ff @(posedge i_dclk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_rst_mmcm  = 1'b0;
        drp.den     = 1'b0;
        drp.dwe     = 1'b0;
        drp.daddr   = '0;
        drp.din     = '0;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_start) w_state_nxt = w_range_err ? S_DONE : S_ASSERT_RST;
            end
            S_ASSERT_RST: begin
                o_rst_mmcm  = 1'b1;
                w_state_nxt = (r_num == '0) ? S_RELEASE : S_READ;
            end
            S_READ: begin
                o_rst_mmcm  = 1'b1;
                drp.den     = 1'b1;
                drp.daddr   = r_tbl_addr[r_idx];
                w_state_nxt = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                o_rst_mmcm = 1'b1;
                if (drp.drdy)      w_state_nxt = S_WRITE;
                else if (w_drdy_to) w_state_nxt = S_RELEASE;
            end
            S_WRITE: begin
                o_rst_mmcm  = 1'b1;
                drp.den     = 1'b1;
                drp.dwe     = 1'b1;
                drp.daddr   = r_tbl_addr[r_idx];
                drp.din     = r_new;
                w_state_nxt = S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                o_rst_mmcm = 1'b1;
                if (drp.drdy)      w_state_nxt = w_last ? S_RELEASE : S_READ;
                else if (w_drdy_to) w_state_nxt = S_RELEASE;
            end
            // A drdy timeout has already raised error; skip the lock wait in that case.
            S_RELEASE:   w_state_nxt = r_error ? S_DONE : S_WAIT_LOCK;
            S_WAIT_LOCK: if (w_lock_ok || w_lock_to) w_state_nxt = S_DONE;
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_dclk or posedge i_rst) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_num       <= '0;
            r_new       <= '0;
            r_cnt       <= '0;
            r_lock_sync <= '0;
            r_error     <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_locked};
            r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_num      <= i_num_active;
                    r_idx      <= '0;
                    r_error    <= w_range_err;
                    r_err_code <= w_range_err ? 2'd3 : 2'd0;
                end
                S_READ_WAIT: begin
                    if (drp.drdy)
                        r_new <= (drp.dout & r_tbl_mask[r_idx]) | (r_tbl_data[r_idx] & ~r_tbl_mask[r_idx]);
                    else if (w_drdy_to) begin
                        r_error    <= 1'b1;
                        r_err_code <= 2'd1;
                    end
                end
                S_WRITE_WAIT: begin
                    if (drp.drdy) r_idx <= r_idx + IDX_W'(1);
                    else if (w_drdy_to) begin
                        r_error    <= 1'b1;
                        r_err_code <= 2'd1;
                    end
                end
                S_WAIT_LOCK: if (!w_lock_ok && w_lock_to) begin
                    r_error    <= 1'b1;
                    r_err_code <= 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign o_error    = r_error;
    assign o_err_code = r_err_code;
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Scoreboard bench: a reference RMW model predicts DRP writes and completion status per start.
module tb_mmcm_drp_sequencer;
    localparam int NE = 23, IW = 5, DTO = 255, LTO = 100;

    logic dclk = 1'b0, rst = 1'b1;
    always #5 dclk = ~dclk;

    logic          tbl_we = 1'b0;
    logic [IW-1:0] tbl_idx = '0;
    logic [6:0]    tbl_addr = '0;
    logic [15:0]   tbl_mask = '0, tbl_data = '0;
    logic [IW:0]   num_active = '0;
    logic          start = 1'b0;
    logic          locked;
    logic          rst_mmcm, ready, done, error;
    logic [1:0]    err_code;

    mmcm_drp_sequencer_if drp ();

    mmcm_drp_sequencer #(.NUM_ENTRIES(NE), .IDX_W(IW), .DRDY_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO)) dut (
        .i_dclk(dclk), .i_rst(rst), .i_tbl_we(tbl_we), .i_tbl_idx(tbl_idx), .i_tbl_addr(tbl_addr),
        .i_tbl_mask(tbl_mask), .i_tbl_data(tbl_data), .i_num_active(num_active), .i_start(start),
        .drp(drp.master), .o_rst_mmcm(rst_mmcm), .i_locked(locked), .o_ready(ready), .o_done(done),
        .o_error(error), .o_err_code(err_code)
    );

    logic [15:0] mem     [128];
    logic [15:0] ref_mem [128];
    logic [6:0]  rt_addr [NE];
    logic [15:0] rt_mask [NE];
    logic [15:0] rt_data [NE];
    logic [22:0] exp_wr [$];
    logic [2:0]  exp_dn [$];

    int checks = 0, errors = 0;
    int max_dly = 0, drop_rd = 0, rd_cnt = 0, lock_dly = 5;
    bit lock_stuck = 1'b0;
    int cyc = 0, den_cnt = 0, rm_rise = 0, last_width = 0, fall_cyc = 0, last_rd_cyc = 0, done_cyc = 0;

    always @(posedge dclk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic fail(input string n);
        checks++;
        errors++;
        $display("FAIL %s", n);
    endtask

    // DRP slave: drdy after a random 0..max_dly extra cycles; optionally swallows one read.
    initial begin : responder
        bit pend;
        int dly;
        logic [15:0] rv;
        pend = 1'b0; dly = 0; rv = '0;
        drp.drdy = 1'b0;
        drp.dout = '0;
        forever begin
            @(negedge dclk);
            drp.drdy = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    drp.drdy = 1'b1;
                    drp.dout = rv;
                    pend = 1'b0;
                end else dly--;
            end
            if (drp.den) begin
                if (drp.dwe) begin
                    mem[drp.daddr] = drp.din;
                    rv = '0;
                    pend = 1'b1;
                end else begin
                    rd_cnt++;
                    rv = mem[drp.daddr];
                    pend = !(drop_rd != 0 && rd_cnt == drop_rd);
                end
                dly = $urandom_range(max_dly, 0);
            end
        end
    end

    initial begin : lock_model
        int c;
        c = 0;
        locked = 1'b0;
        forever begin
            @(negedge dclk);
            if (rst_mmcm) begin
                locked = 1'b0;
                c = 0;
            end else if (!lock_stuck) begin
                if (c >= lock_dly) locked = 1'b1;
                else c++;
            end
        end
    end

    initial begin : monitor
        bit prev_den, prev_rm;
        int width;
        logic [22:0] w;
        logic [2:0]  d;
        prev_den = 1'b0; prev_rm = 1'b0; width = 0;
        forever begin
            @(negedge dclk);
            if (!rst) begin
                if (drp.den) begin
                    den_cnt++;
                    chk("den_gap_and_rst", {30'd0, prev_den, rst_mmcm}, 32'd1);
                    if (!drp.dwe) last_rd_cyc = cyc;
                    else if (exp_wr.size() == 0) fail("unexpected_write");
                    else begin
                        w = exp_wr.pop_front();
                        chk("drp_write", {9'd0, drp.daddr, drp.din}, {9'd0, w});
                    end
                end
                if (rst_mmcm && !prev_rm) rm_rise++;
                if (done) begin
                    done_cyc = cyc;
                    if (exp_dn.size() == 0) fail("unexpected_done");
                    else begin
                        d = exp_dn.pop_front();
                        chk("done_status", {29'd0, error, err_code}, {29'd0, d});
                    end
                end
            end
            if (rst_mmcm) width++;
            if (!rst_mmcm && prev_rm) begin
                last_width = width;
                width = 0;
                fall_cyc = cyc;
            end
            prev_den = drp.den;
            prev_rm  = rst_mmcm;
        end
    end

    task automatic tbl_write(input int idx, input logic [6:0] a, input logic [15:0] m, input logic [15:0] dd);
        tbl_we = 1'b1; tbl_idx = IW'(idx); tbl_addr = a; tbl_mask = m; tbl_data = dd;
        if (ready && idx < NE) begin
            rt_addr[idx] = a; rt_mask[idx] = m; rt_data[idx] = dd;
        end
        @(negedge dclk);
        tbl_we = 1'b0;
    endtask

    task automatic issue(input int n);
        int k, lim;
        logic [15:0] nv;
        k = 0;
        while (!ready && k < 3000) begin @(negedge dclk); k++; end
        if (!ready) fail("ready_before_start_timeout");
        if (n > NE) exp_dn.push_back(3'b111);
        else begin
            lim = (drop_rd != 0 && drop_rd <= n) ? drop_rd - 1 : n;
            for (int i = 0; i < lim; i++) begin
                nv = (ref_mem[rt_addr[i]] & rt_mask[i]) | (rt_data[i] & ~rt_mask[i]);
                ref_mem[rt_addr[i]] = nv;
                exp_wr.push_back({rt_addr[i], nv});
            end
            exp_dn.push_back(lim < n ? 3'b101 : (lock_stuck ? 3'b110 : 3'b000));
        end
        rd_cnt = 0; den_cnt = 0; rm_rise = 0;
        start = 1'b1;
        num_active = (IW+1)'(n);
        @(negedge dclk);
        start = 1'b0;
        if (n > NE) chk("range_done_next", {30'd0, done, ready}, 32'd2);
        else        chk("start_clears_error", {30'd0, error, ready}, 32'd0);
    endtask

    task automatic finish_run();
        int k;
        k = 0;
        while (!ready && k < 3000) begin @(negedge dclk); k++; end
        if (!ready) fail("sequence_end_timeout");
        chk("queues_drained", {30'd0, exp_wr.size() == 0, exp_dn.size() == 0}, 32'd3);
    endtask

    initial begin : stim
        int k, n;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        ref_mem = mem;
        repeat (3) @(negedge dclk);
        chk("reset_outputs", {24'd0, ready, done, error, err_code, rst_mmcm, drp.den, drp.dwe}, 32'h80);
        rst = 1'b0;
        @(negedge dclk);
        for (int i = 0; i < NE; i++) tbl_write(i, 7'($urandom), 16'($urandom), 16'($urandom));

        // Two-entry directed sequence, zero-wait drdy.
        mem[8] = 16'hFFFF; mem[20] = 16'hFFFF; ref_mem[8] = 16'hFFFF; ref_mem[20] = 16'hFFFF;
        tbl_write(0, 7'h08, 16'h1000, 16'h0145);
        tbl_write(1, 7'h14, 16'h1000, 16'h0208);
        lock_dly = 10; max_dly = 0;
        issue(2); finish_run();
        chk("t1_reg08", 32'(mem[8]), 32'h1145);
        chk("t1_reg14", 32'(mem[20]), 32'h1208);
        chk("t1_rst_width", 32'(last_width), 32'd9);
        chk("t1_den_count", 32'(den_cnt), 32'd4);

        issue(0); finish_run();
        chk("t2_no_den", 32'(den_cnt), 32'd0);
        chk("t2_rst_pulse", 32'(last_width), 32'd1);

        drop_rd = 2;
        issue(2); finish_run();
        drop_rd = 0;
        chk("t3_den_count", 32'(den_cnt), 32'd3);
        chk("t3_drdy_timeout_cycles", 32'(fall_cyc - last_rd_cyc), 32'd256);

        lock_stuck = 1'b1;
        issue(1); finish_run();
        lock_stuck = 1'b0;
        chk("t4_lock_timeout_cycles", 32'(done_cyc - fall_cyc), 32'd101);
        chk("t4_error_sticky", {29'd0, error, err_code}, 32'd6);
        issue(1); finish_run();

        issue(24); finish_run();
        chk("t5_no_den", 32'(den_cnt), 32'd0);
        chk("t5_rst_untouched", 32'(rm_rise), 32'd0);

        // start and tbl_we while busy must be ignored; the next run proves entry 0 is unchanged.
        max_dly = 3;
        issue(2);
        @(negedge dclk);
        chk("busy_not_ready", {31'd0, ready}, 32'd0);
        start = 1'b1; tbl_we = 1'b1; tbl_idx = '0; tbl_addr = 7'h55; tbl_mask = '0; tbl_data = 16'hDEAD;
        @(negedge dclk);
        start = 1'b0; tbl_we = 1'b0;
        finish_run();
        issue(1); finish_run();

        // Reset in WRITE_WAIT.
        max_dly = 2;
        issue(2);
        k = 0;
        while (!(drp.den && drp.dwe) && k < 200) begin @(negedge dclk); k++; end
        if (!(drp.den && drp.dwe)) fail("write_not_seen");
        @(negedge dclk);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {27'd0, drp.den, drp.dwe, rst_mmcm, done, ready}, 32'd1);
        @(negedge dclk); @(negedge dclk);
        rst = 1'b0;
        exp_wr.delete(); exp_dn.delete();
        repeat (6) @(negedge dclk);
        ref_mem = mem;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        max_dly = 0;
        issue(2); finish_run();

        for (int r = 0; r < 10; r++) begin
            lock_dly = $urandom_range(15, 0);
            max_dly  = $urandom_range(3, 0);
            k = $urandom_range(10, 1);
            for (int j = 0; j < k; j++)
                tbl_write($urandom_range(31, 0), 7'($urandom), 16'($urandom), 16'($urandom));
            n = ($urandom_range(7, 0) == 0) ? $urandom_range(31, 24) : $urandom_range(NE, 0);
            issue(n); finish_run();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Parametrised DRP reconfiguration engine for 7-series MMCME2/PLLE2, in the dclk domain next to the MMCM.
- Holds a loadable table of up to NUM_ENTRIES (address, mask, data) entries.
- On start: holds the MMCM in reset, applies every active entry as a read-modify-write over DRP, releases reset, then waits for lock with timeouts.
- Generalises the fixed-register reconfig block: runtime table, entry count, masking, drdy/lock timeouts, error reporting.

Parameters:
- NUM_ENTRIES, 23, table depth (maximum entries per sequence).
- IDX_W, 5, table index width (≥ clog2(NUM_ENTRIES)).
- DRDY_TIMEOUT, 255, dclk cycles to wait for drdy before aborting.
- LOCK_TIMEOUT, 65535, dclk cycles to wait for synchronised locked after reset release.

Ports:
- dclk  in  1  DRP clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- tbl_we  in  1  table write strobe; honoured only while ready=1.
- tbl_idx  in  IDX_W  table entry index; writes with idx ≥ NUM_ENTRIES are ignored.
- tbl_addr  in  7  DRP address for the entry.
- tbl_mask  in  16  bit=1 keeps the current register bit.
- tbl_data  in  16  new bits where mask=0.
- num_active  in  IDX_W+1  entries to apply (0..NUM_ENTRIES); sampled at start.
- start  in  1  one-cycle request; honoured only while ready=1.
- daddr  out  7  DRP address.
- din  out  16  DRP write data.
- den  out  1  DRP enable.
- dwe  out  1  DRP write enable.
- dout  in  16  DRP read data.
- drdy  in  1  DRP ready.
- rst_mmcm  out  1  MMCM reset.
- locked  in  1  MMCM LOCKED; asynchronous, internally 2-flop synchronised.
- ready  out  1  idle, accepting start and table writes.
- done  out  1  one-cycle pulse at end of every sequence.
- error  out  1  sticky until the next accepted start.
- err_code  out  2  0=none, 1=drdy timeout, 2=lock timeout, 3=num_active out of range.

Behaviour:
- Reset (async assert, sync release): state IDLE; ready=1; all other outputs 0; err_code=0. Table contents are undefined after reset.
- Table write: on posedge with tbl_we & ready & idx<NUM_ENTRIES, the entry is stored. It is visible to a start in the next cycle or later.
- start & ready accepted:
  - If num_active > NUM_ENTRIES: error=1, err_code=3, done pulses the next cycle, no DRP traffic, rst_mmcm untouched.
  - If num_active = 0: rst_mmcm pulses for 1 cycle, then WAIT_LOCK.
  - Otherwise: ready=0, error cleared, idx=0, then ASSERT_RST.
- ASSERT_RST: rst_mmcm=1 (held until RELEASE) → READ.
- READ: den=1, dwe=0, daddr=entry.addr for exactly one cycle → READ_WAIT.
- READ_WAIT: on drdy, latch new = (dout & mask) | (data & ~mask) → WRITE.
- WRITE: den=1, dwe=1, daddr=entry.addr, din=new for one cycle → WRITE_WAIT.
- WRITE_WAIT: on drdy, idx+1. If idx+1 = num_active → RELEASE, else → READ.
- Timeouts in READ_WAIT/WRITE_WAIT: counter clears on entering the state. If no drdy after DRDY_TIMEOUT cycles: err_code=1, error=1 → RELEASE with lock wait skipped → DONE.
- Stray drdy outside a wait state is ignored.
- RELEASE: rst_mmcm=0 → WAIT_LOCK.
- WAIT_LOCK: exit on synchronised locked=1 → DONE. If the counter reaches LOCK_TIMEOUT: err_code=2, error=1 → DONE. locked still high from before release must not satisfy the wait; require at least 4 cycles after release before sampling.
- DONE: done=1 for one cycle, ready=1 the next cycle → IDLE.
- Only one DRP transaction is outstanding at a time. den is never high on two consecutive cycles.
- Latency with zero-wait drdy (drdy the cycle after den): per entry 4 cycles.
- Async reset mid-sequence: all outputs go to reset values immediately, including rst_mmcm=0. The caller must re-run the sequence.
- start while busy: ignored, no queueing. tbl_we while busy: ignored.

Test Plan:
- Load 2 entries {0x08, mask 0x1000, data 0x0145}, {0x14, mask 0x1000, data 0x0208}; DRP model reads 0xFFFF; locked 10 cycles after release → writes din=0x1145 to 0x08 then 0x1208 to 0x14, rst_mmcm high throughout, done pulse, error=0.
- num_active=0 → no den, rst_mmcm single-cycle pulse, done after lock.
- DRP model never returns drdy on the 2nd read, DRDY_TIMEOUT=255 → err_code=1 after 255 cycles, rst_mmcm drops, done pulses, no further den.
- locked stuck at 0, LOCK_TIMEOUT=100 → err_code=2 about 100 cycles after release. The next accepted start clears error.
- num_active=24 with NUM_ENTRIES=23 → err_code=3, done the next cycle, no DRP traffic. start and tbl_we during a sequence → ignored, table unchanged.
- Assert rst during WRITE_WAIT → den/dwe/rst_mmcm/done go 0 immediately and ready=1 after release. A fresh start then completes normally.
